lsu_writeback: RTL

- Load/store unit between the execute stage and the register-file write port.
- Accepts one memory operation at a time and runs a req/ack handshake to data memory.
- Generates byte enables and lane-replicated store data; extracts and sign/zero-extends load data.
- Drives a single-cycle register write (rd, data, we) into the register file, and stalls the pipeline while busy.

---
 rtl/lsu_writeback.sv | 131 +++++++++++++
 1 files changed

// File: rtl/lsu_writeback.sv
// lsu_writeback: single-outstanding load/store unit driving a req/ack data bus and a one-cycle register writeback.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses on a misalign_fault output.
module lsu_writeback #(
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_load,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        stall,
    output logic        bus_err
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign_fault
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic [1:0] S_MIS  = 2'd3;
`endif
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]           r_state;
    logic                 r_load;
    logic [2:0]           r_f3;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_wb_data;
    logic [4:0]           r_rd;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_bus_err;
    logic [1:0]           w_off;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_ext;
    logic [3:0]           w_be;
    logic [31:0]          w_st_data;

    assign w_off  = r_addr[1:0];
    assign w_byte = mem_rdata[{w_off, 3'b000} +: 8];
    assign w_half = w_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // funct3[2] selects zero-extension; codes with funct3[1] set are whole-word loads
    assign w_ext  = (r_f3[1:0] == 2'b00) ? {{24{!r_f3[2] && w_byte[7]}}, w_byte} :
                    (r_f3[1:0] == 2'b01) ? {{16{!r_f3[2] && w_half[15]}}, w_half} : mem_rdata;
    assign w_be   = r_load ? 4'hF :
                    (r_f3 == 3'b000) ? 4'b0001 << w_off :
                    (r_f3 == 3'b001) ? (w_off[1] ? 4'hC : 4'h3) : 4'hF;
    assign w_st_data = (r_f3 == 3'b000) ? {4{r_wdata[7:0]}} :
                       (r_f3 == 3'b001) ? {2{r_wdata[15:0]}} : r_wdata;

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_half_acc;
    logic w_fault;
    assign w_half_acc = op_load ? (funct3[1:0] == 2'b01) : (funct3 == 3'b001);
    assign w_fault    = w_half_acc ? addr[0] :
                        (op_load ? (funct3[1:0] != 2'b00) : (funct3 != 3'b000)) && (addr[1:0] != 2'b00);
    assign misalign_fault = (r_state == S_MIS);
`endif

    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = mem_req && !r_load;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = w_st_data;
    assign mem_be    = mem_req ? w_be : 4'h0;
    assign wb_we     = (r_state == S_WB) && (r_rd != 5'd0);
    assign wb_rd     = r_rd;
    assign wb_data   = r_wb_data;
    assign stall     = (r_state != S_IDLE);
    assign op_ready  = (r_state == S_IDLE);
    assign bus_err   = r_bus_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_load    <= 1'b0;
            r_f3      <= 3'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wb_data <= 32'd0;
            r_rd      <= 5'd0;
            r_cnt     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: if (op_valid) begin
                    r_load  <= op_load;
                    r_f3    <= funct3;
                    r_addr  <= addr;
                    r_wdata <= wdata;
                    r_rd    <= rd;
`ifdef LSU_MISALIGN_TRAP_EN
                    r_state <= w_fault ? S_MIS : S_REQ;
`else
                    r_state <= S_REQ;
`endif
                end
                S_REQ: if (mem_ack) begin
                    r_cnt   <= '0;
                    if (r_load) r_wb_data <= w_ext;
                    r_state <= r_load ? S_WB : S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    r_cnt     <= '0;
                    r_bus_err <= 1'b1;
                    r_state   <= S_IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
